// File: rtl/draw_pkg.sv
// Shared constants for the rectangle draw engine: command modes, FSM state
// encoding, default screen geometry and the palette entries used by the game FSM.
// No ports; imported by rect_draw_engine and its testbench.
package draw_pkg;

   typedef logic [1:0] mode_t;
   typedef logic [1:0] state_t;

   localparam mode_t MODE_RECT    = 2'd0;
   localparam mode_t MODE_CLEAR   = 2'd1;
   localparam mode_t MODE_OUTLINE = 2'd2;
   localparam mode_t MODE_RSVD    = 2'd3;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_DRAW = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] GREEN = 3'b010;
   localparam logic [2:0] RED   = 3'b100;

   // Reserved mode produces no pixels at all.
   function automatic logic mode_draws(input mode_t m);
      return m != MODE_RSVD;
   endfunction

endpackage

// File: rtl/scan_counter_2d.sv
// Row-major 2D scan counter: cx runs 0..w-1, wrapping into cy 0..h-1.
// Latency: counters update on the edge where enable is high; flags are combinational.
// Backpressure: enable low freezes both counters. Ports: clear/enable, w/h in; cx/cy and edge flags out.
module scan_counter_2d #(
   parameter int X_W = 8,
   parameter int Y_W = 7
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           clear,
   input  logic           enable,
   input  logic [X_W-1:0] w,
   input  logic [Y_W-1:0] h,
   output logic [X_W-1:0] cx,
   output logic [Y_W-1:0] cy,
   output logic           first_col,
   output logic           last_col,
   output logic           first_row,
   output logic           last_row,
   output logic           last
);

   logic [X_W-1:0] cx_q, cx_d;
   logic [Y_W-1:0] cy_q, cy_d;

   assign cx        = cx_q;
   assign cy        = cy_q;
   assign first_col = (cx_q == '0);
   assign last_col  = (cx_q == w - X_W'(1));
   assign first_row = (cy_q == '0);
   assign last_row  = (cy_q == h - Y_W'(1));
   assign last      = last_col & last_row;

   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (clear) begin
         cx_d = '0;
         cy_d = '0;
      end else if (enable) begin
         if (last_col) begin
            cx_d = '0;
            cy_d = last_row ? '0 : cy_q + Y_W'(1);
         end else begin
            cx_d = cx_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end

endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: takes one draw command, emits one clipped pixel per cycle, then pulses done.
// Latency: pixel k plots 2+k cycles after accept; done at 2+w*h (1 for empty commands).
// Backpressure: stall freezes the scan and forces plot low. Ports: cmd_* handshake in; xout/yout/cout/plot, done, busy out.
module rect_draw_engine
   import draw_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int C_W      = 3,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [1:0]     cmd_mode,
   input  logic [X_W-1:0] cmd_x0,
   input  logic [Y_W-1:0] cmd_y0,
   input  logic [X_W-1:0] cmd_w,
   input  logic [Y_W-1:0] cmd_h,
   input  logic [C_W-1:0] cmd_colour,
   input  logic           stall,
   output logic [X_W-1:0] xout,
   output logic [Y_W-1:0] yout,
   output logic [C_W-1:0] cout,
   output logic           plot,
   output logic           done,
   output logic           busy
);

   localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

   state_t         state_q, state_d;
   logic           drain_q, drain_d;
   logic [X_W-1:0] x0_q, x0_d, w_q, w_d;
   logic [Y_W-1:0] y0_q, y0_d, h_q, h_d;
   logic [C_W-1:0] col_q, col_d;
   mode_t          mode_q, mode_d;
   logic [X_W-1:0] xout_q, xout_d;
   logic [Y_W-1:0] yout_q, yout_d;
   logic [C_W-1:0] cout_q, cout_d;
   logic           plot_q, plot_d;

   logic [X_W-1:0] cx;
   logic [Y_W-1:0] cy;
   logic           first_col, last_col, first_row, last_row, last;

   logic           accept, is_clear, empty, scan_en, mode_ok, visible;
   logic [X_W-1:0] eff_x0, eff_w;
   logic [Y_W-1:0] eff_y0, eff_h;
   logic [X_W:0]   sum_x;
   logic [Y_W:0]   sum_y;

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign xout      = xout_q;
   assign yout      = yout_q;
   assign cout      = cout_q;
   assign plot      = plot_q;

   assign accept   = cmd_ready & cmd_valid;
   assign is_clear = (cmd_mode == MODE_CLEAR);
   assign eff_x0   = is_clear ? '0 : cmd_x0;
   assign eff_y0   = is_clear ? '0 : cmd_y0;
   assign eff_w    = is_clear ? X_W'(SCREEN_W) : cmd_w;
   assign eff_h    = is_clear ? Y_W'(SCREEN_H) : cmd_h;
   assign empty    = (eff_w == '0) | (eff_h == '0) | ~mode_draws(cmd_mode);

   // drain_q marks the cycle after the last pixel was scanned; the FSM waits
   // there so done lines up one cycle behind the registered pixel stage.
   assign scan_en = (state_q == ST_DRAW) & ~drain_q & ~stall;

   scan_counter_2d #(.X_W(X_W), .Y_W(Y_W)) u_scan (
      .clock     (clock),
      .reset     (reset),
      .clear     (accept),
      .enable    (scan_en),
      .w         (w_q),
      .h         (h_q),
      .cx        (cx),
      .cy        (cy),
      .first_col (first_col),
      .last_col  (last_col),
      .first_row (first_row),
      .last_row  (last_row),
      .last      (last)
   );

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               x0_d    = eff_x0;
               y0_d    = eff_y0;
               w_d     = eff_w;
               h_d     = eff_h;
               col_d   = cmd_colour;
               mode_d  = cmd_mode;
               drain_d = 1'b0;
               state_d = empty ? ST_DONE : ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (drain_q) begin
               if (!stall) begin
                  drain_d = 1'b0;
                  state_d = ST_DONE;
               end
            end else if (scan_en && last) begin
               drain_d = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel stage: sums are one bit wider so a wrap past the coordinate range clips.
   always_comb begin
      sum_x   = {1'b0, x0_q} + {1'b0, cx};
      sum_y   = {1'b0, y0_q} + {1'b0, cy};
      mode_ok = (mode_q == MODE_OUTLINE) ? (first_col | last_col | first_row | last_row) : 1'b1;
      visible = ~sum_x[X_W] & ~sum_y[Y_W] & (sum_x < SCR_W) & (sum_y < SCR_H);
      plot_d  = scan_en & visible & mode_ok;
      xout_d  = scan_en ? sum_x[X_W-1:0] : xout_q;
      yout_d  = scan_en ? sum_y[Y_W-1:0] : yout_q;
      cout_d  = plot_d ? col_q : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         drain_q <= 1'b0;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         mode_q  <= MODE_RECT;
         xout_q  <= '0;
         yout_q  <= '0;
         cout_q  <= '0;
         plot_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         mode_q  <= mode_d;
         xout_q  <= xout_d;
         yout_q  <= yout_d;
         cout_q  <= cout_d;
         plot_q  <= plot_d;
      end
   end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Self-checking bench for rect_draw_engine: command table plus reset/stall sequences,
// with a pixel scoreboard filled from a reference rasteriser when each command is issued.
// No ports.
module tb_rect_draw_engine;
   import draw_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_mode;
   logic [7:0] cmd_x0;
   logic [6:0] cmd_y0;
   logic [7:0] cmd_w;
   logic [6:0] cmd_h;
   logic [2:0] cmd_colour;
   logic       stall;
   logic [7:0] xout;
   logic [6:0] yout;
   logic [2:0] cout;
   logic       plot;
   logic       done;
   logic       busy;

   rect_draw_engine dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_colour(cmd_colour), .stall(stall),
      .xout(xout), .yout(yout), .cout(cout), .plot(plot), .done(done), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   typedef struct {
      logic [1:0] mode;
      int x0, y0, w, h, col;
      int exp_plots;
      int exp_done;
      int stall_at, stall_len;
   } vec_t;

   pix_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   plot_cnt = 0;
   int   first_plot_cyc = -1;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference rasteriser: every visible pixel of the command in scan order.
   task automatic push_model(input logic [1:0] m, input int x0, input int y0,
                             input int w, input int h, input int col);
      int ex0, ey0, ew, eh;
      ex0 = x0; ey0 = y0; ew = w; eh = h;
      if (m == MODE_CLEAR) begin
         ex0 = 0; ey0 = 0; ew = 160; eh = 120;
      end
      if (m == MODE_RSVD) return;
      for (int yy = 0; yy < eh; yy++) begin
         for (int xx = 0; xx < ew; xx++) begin
            int   sx, sy;
            bit   on_edge;
            pix_t p;
            sx = ex0 + xx;
            sy = ey0 + yy;
            on_edge = (xx == 0) || (xx == ew - 1) || (yy == 0) || (yy == eh - 1);
            if (sx < 160 && sy < 120 && (m != MODE_OUTLINE || on_edge)) begin
               p.x = sx[7:0];
               p.y = sy[6:0];
               p.c = col[2:0];
               sb.push_back(p);
            end
         end
      end
   endtask

   // Pixel monitor: every plot pulse is matched against the scoreboard head.
   always @(negedge clock) begin
      if (plot === 1'b1) begin
         pix_t got;
         got = {xout, yout, cout};
         plot_cnt++;
         if (first_plot_cyc < 0) first_plot_cyc = cyc;
         check("scoreboard_has_pixel", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            pix_t exp;
            exp = sb.pop_front();
            if (got !== exp)
               $display("  pixel got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                        got.x, got.y, got.c, exp.x, exp.y, exp.c);
            check("pixel", int'(got), int'(exp));
         end
      end
   end

   task automatic issue(input vec_t v, output int n);
      @(negedge clock);
      check("cmd_ready_before_issue", int'(cmd_ready), 1);
      cmd_valid  = 1'b1;
      cmd_mode   = v.mode;
      cmd_x0     = v.x0[7:0];
      cmd_y0     = v.y0[6:0];
      cmd_w      = v.w[7:0];
      cmd_h      = v.h[6:0];
      cmd_colour = v.col[2:0];
      n = cyc;
      plot_cnt = 0;
      first_plot_cyc = -1;
      push_model(v.mode, v.x0, v.y0, v.w, v.h, v.col);
      @(posedge clock);
      #1;
      // Keep valid high with junk fields: the engine must ignore them while busy.
      cmd_mode   = 2'($urandom);
      cmd_x0     = 8'($urandom);
      cmd_y0     = 7'($urandom);
      cmd_w      = 8'($urandom);
      cmd_h      = 7'($urandom);
      cmd_colour = 3'($urandom);
   endtask

   task automatic run(input vec_t v);
      int n, k;
      bit got_done;
      got_done = 1'b0;
      issue(v, n);
      for (int t = 0; t < 25000 && !got_done; t++) begin
         @(negedge clock);
         k = cyc - n;
         if (k == 1) begin
            check("busy_after_accept", int'(busy), 1);
            check("ready_low_after_accept", int'(cmd_ready), 0);
         end
         if (v.stall_len > 0 && k > v.stall_at && k <= v.stall_at + v.stall_len)
            check("plot_low_during_stall", int'(plot), 0);
         stall = (k >= v.stall_at && k < v.stall_at + v.stall_len);
         if (done === 1'b1) begin
            got_done = 1'b1;
            cmd_valid = 1'b0;
            check("done_latency", k, v.exp_done);
         end
      end
      check("done_seen", int'(got_done), 1);
      stall = 1'b0;
      cmd_valid = 1'b0;
      check("plot_count", plot_cnt, v.exp_plots);
      check("scoreboard_drained", sb.size(), 0);
      if (v.exp_plots > 0) check("first_plot_latency", first_plot_cyc - n, 2);
      @(negedge clock);
      check("done_single_cycle", int'(done), 0);
      check("ready_after_done", int'(cmd_ready), 1);
      check("idle_after_done", int'(busy), 0);
      sb.delete();
   endtask

   vec_t vecs[9];
   vec_t v1, vclr;

   initial begin
      int n, seen_done;
      //         mode          x0   y0  w   h   col plots  done   st  sl
      vecs[0] = '{MODE_RECT,    10,  20, 2,  2,  4,  4,     6,     0,  0};
      vecs[1] = '{MODE_OUTLINE,  0,   0, 4,  3,  2,  10,    14,    0,  0};
      vecs[2] = '{MODE_RECT,   158, 118, 4,  4,  1,  4,     18,    0,  0};
      vecs[3] = '{MODE_RECT,   250,   5, 10, 2,  3,  0,     22,    0,  0};
      vecs[4] = '{MODE_RECT,    10,  20, 2,  2,  4,  4,     9,     2,  3};
      vecs[5] = '{MODE_RECT,     5,   5, 0,  3,  7,  0,     1,     0,  0};
      vecs[6] = '{MODE_RECT,     5,   5, 3,  0,  7,  0,     1,     0,  0};
      vecs[7] = '{MODE_RSVD,     5,   5, 3,  3,  7,  0,     1,     0,  0};
      vecs[8] = '{MODE_CLEAR,   33,   9, 0,  0,  0,  19200, 19202, 0,  0};

      reset = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_x0 = '0; cmd_y0 = '0;
      cmd_w = '0; cmd_h = '0; cmd_colour = '0; stall = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_xout", int'(xout), 0);
      check("rst_yout", int'(yout), 0);
      check("rst_cout", int'(cout), 0);
      check("rst_plot", int'(plot), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_cmd_ready", int'(cmd_ready), 1);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run(vecs[i]);

      // Reset in the middle of a CLEAR: command dropped, no done pulse.
      vclr = vecs[8];
      issue(vclr, n);
      repeat (40) @(negedge clock);
      reset = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clock);
      check("midrst_xout", int'(xout), 0);
      check("midrst_yout", int'(yout), 0);
      check("midrst_cout", int'(cout), 0);
      check("midrst_plot", int'(plot), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_cmd_ready", int'(cmd_ready), 1);
      reset = 1'b0;
      sb.delete();
      seen_done = 0;
      repeat (6) begin
         @(negedge clock);
         if (done === 1'b1 || plot === 1'b1) seen_done++;
      end
      check("no_activity_after_reset", seen_done, 0);

      // A normal command goes through afterwards.
      v1 = vecs[0];
      v1.col = GREEN;
      run(v1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
Parametrised rectangle rasteriser for the VGA game pipeline.
- Accepts one draw command (origin, size, colour, mode) over a valid/ready handshake.
- Scans the region in row-major order and emits one (x, y, colour, plot) pixel per cycle to the VGA adapter, with clipping and stall support.
- Raises a one-cycle done pulse on completion.
- Replaces the fixed black/green/car draw paths: the FSM issues one command per background band or sprite.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
C_W, 3, colour width
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_mode  in  2  0 RECT, 1 CLEAR, 2 OUTLINE, 3 reserved
cmd_x0  in  X_W  region left column
cmd_y0  in  Y_W  region top row
cmd_w  in  X_W  region width in pixels
cmd_h  in  Y_W  region height in pixels
cmd_colour  in  C_W  fill colour
stall  in  1  downstream not ready; freeze the scan
xout  out  X_W  pixel column
yout  out  Y_W  pixel row
cout  out  C_W  pixel colour
plot  out  1  write strobe for xout/yout/cout
done  out  1  one-cycle completion pulse
busy  out  1  high outside IDLE

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1. State is IDLE, counters cx = cy = 0.
- Reset mid-command: return to IDLE on the next edge. No done pulse; the command is dropped.
- IDLE state:
  - cmd_ready = 1.
  - Accept occurs when cmd_valid & cmd_ready at an edge. That edge latches x0, y0, w, h, colour and mode, and moves to DRAW.
  - CLEAR overrides the latched region with x0 = 0, y0 = 0, w = SCREEN_W, h = SCREEN_H.
  - w = 0, h = 0, or mode 3: go directly to DONE (no pixels).
- DRAW state:
  - cmd_ready = 0.
  - Each non-stalled cycle advances cx: cx = w-1 wraps cx to 0 and increments cy. cx = w-1 with cy = h-1 is the last pixel; go to DONE.
  - stall = 1 holds cx, cy and the state. The plot register loads 0 for that cycle.
- Pixel stage is registered, one cycle behind the counters:
  - xout = x0 + cx and yout = y0 + cy, each computed one bit wider than its port.
  - plot = 1 only if all of the following hold: not stalled, no carry out of the wide sum, xout < SCREEN_W, yout < SCREEN_H, and the mode condition.
  - Mode condition: RECT and CLEAR always pass. OUTLINE passes only when cx = 0, cx = w-1, cy = 0 or cy = h-1.
  - Clipped or interior cycles still consume a cycle but plot = 0. A command therefore always takes exactly w*h non-stalled DRAW cycles.
  - cout = latched colour whenever plot = 1.
- DONE state: lasts one cycle; done = 1, cmd_ready = 0. Then return to IDLE.
- Timing with no stalls, command accepted at the edge ending cycle N:
  - Pixel k has plot = 1 in cycle N+2+k.
  - done is high in cycle N+2+w*h.
  - cmd_ready is high again in cycle N+3+w*h.
  - The empty case (w = 0, h = 0 or mode 3) has done in cycle N+1.
- Each stall cycle delays all later events by one cycle.
- cmd_* inputs are ignored while busy.

Decomposition:
- Package draw_pkg:
  - mode constants MODE_RECT, MODE_CLEAR, MODE_OUTLINE, MODE_RSVD;
  - FSM state encoding IDLE, DRAW, DONE;
  - default screen constants 160x120;
  - colour constants BLACK = 3'b000, GREEN = 3'b010, RED = 3'b100.
- One sub-module, scan_counter_2d:
  - parametrised X_W/Y_W;
  - inputs clear, enable (= DRAW & ~stall), w, h;
  - outputs cx, cy, first_col, last_col, first_row, last_row, last.

Test Plan:
1. RECT x0 = 10, y0 = 20, w = 2, h = 2, colour 3'b100, no stall -> plot in cycles N+2..N+5 at (10,20), (11,20), (10,21), (11,21) with cout = 4; done in cycle N+6; cmd_ready in cycle N+7.
2. CLEAR colour 0 -> exactly 19200 plot pulses, first (0,0), last (159,119); done in cycle N+19202.
3. OUTLINE x0 = 0, y0 = 0, w = 4, h = 3 -> 10 plots (interior (1,1) and (2,1) suppressed); done in cycle N+14.
4. Clipping: RECT x0 = 158, y0 = 118, w = 4, h = 4 -> plots only at (158..159, 118..119), 4 pulses; done in cycle N+18. Also x0 = 250, w = 10: carry and clipping give 0 plots; done still in cycle N+2+10*h.
5. Stall: case 1 with stall high for 3 cycles after the first pixel -> same 4 pixels in the same order; done in cycle N+9; plot = 0 during the stall.
6. Edge cases: w = 0 -> done in cycle N+1, no plots. Reset asserted mid-CLEAR -> next cycle all outputs 0, cmd_ready = 1, no done. A new command is accepted normally afterwards.
